// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the counter-width helper.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit-counter width; a one-bit operand still needs a one-bit counter.
  function automatic int clog2_min1(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout set when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first,
// using a single full-subtractor cell.
//
// Handshake: start is a request sampled only while busy == 0; the operands
// a/b/bin are captured on that same edge and are don't-care otherwise.
// busy stays high from the accepting edge through the done cycle; done is a
// one-cycle pulse during which diff/bout carry the new result. diff/bout hold
// until the next completion and never show partial results.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = clog2_min1(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] pr_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             bit_d;
  logic             bit_bout;

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign busy = (state != IDLE);

  // Next partial result (new bit enters at the MSB) and FSM next state.
  always_comb begin
    pr_next            = pr >> 1;
    pr_next[WIDTH-1]   = bit_d;
    last_bit           = (cnt == CW'(WIDTH - 1));
    state_next         = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand shift registers, borrow, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      pr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= bit_bout;
          pr  <= pr_next;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            diff <= pr_next;
            bout <= bit_bout;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) and the full_subtractor cell.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic bin;
    logic d;
    logic bout;
  } fs_vec_t;

  vec_t    vecs[6];
  fs_vec_t fs_vecs[8];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  full_subtractor u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic, borrow appears as bit W.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) fail({name, "_idle"});
  endtask

  // Issue one operation and check latency and result against the model.
  task automatic run_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic obin);
    logic [W:0]   exp;
    logic [W-1:0] prev_diff;
    logic         prev_bout;
    logic         held;
    int           n;
    wait_idle(name);
    exp       = model(oa, ob, obin);
    prev_diff = diff;
    prev_bout = bout;
    held      = 1'b1;
    start = 1'b1;
    a     = oa;
    b     = ob;
    bin   = obin;
    tick();
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    bin   = 1'($urandom_range(0, 1));
    check({name, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      if (done) break;
      if (diff !== prev_diff || bout !== prev_bout) held = 1'b0;
    end
    if (!done) begin
      fail({name, "_done"});
    end else begin
      check({name, "_latency"}, 32'(n), 32'(W));
      check({name, "_hold"}, 32'(held), 32'd1);
      check({name, "_diff"}, 32'(diff), 32'(exp[W-1:0]));
      check({name, "_bout"}, 32'(bout), 32'(exp[W]));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W:0]   e;
    int           n, ndone, last_n;

    // Known-answer vectors
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    fs_vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fs_vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fs_vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    fs_vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    fs_vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    fs_vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fs_vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fs_vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Cell truth table
    for (int i = 0; i < 8; i++) begin
      fs_a   = fs_vecs[i].a;
      fs_b   = fs_vecs[i].b;
      fs_bin = fs_vecs[i].bin;
      #1;
      check($sformatf("fs_d_%0d", i), 32'(fs_d), 32'(fs_vecs[i].d));
      check($sformatf("fs_bout_%0d", i), 32'(fs_bout), 32'(fs_vecs[i].bout));
    end

    // T1: reset held with start high
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h3C;
    bin   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
      check($sformatf("rst_done_%0d", i), 32'(done), 32'd0);
      check($sformatf("rst_diff_%0d", i), 32'(diff), 32'd0);
      check($sformatf("rst_bout_%0d", i), 32'(bout), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // T2/T3: known-answer table
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin);
      check($sformatf("vec%0d_tab_diff", i), 32'(diff), 32'(vecs[i].diff));
      check($sformatf("vec%0d_tab_bout", i), 32'(bout), 32'(vecs[i].bout));
    end

    // T4: start re-asserted with other operands during RUN and DONE
    wait_idle("t4");
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h3C;
    bin   = 1'b0;
    tick();
    a = 8'hFF;
    b = 8'h00;
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      check($sformatf("t4_busy_%0d", n), 32'(busy), 32'd1);
      if (done) break;
    end
    if (!done) begin
      fail("t4_done");
    end else begin
      check("t4_latency", 32'(n), 32'(W));
      check("t4_diff", 32'(diff), 32'h1E);
      check("t4_bout", 32'(bout), 32'd0);
    end
    start = 1'b0;
    tick();
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_done", 32'(done), 32'd0);

    // T5: reset four cycles into RUN aborts the operation
    wait_idle("t5");
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_bout", 32'(bout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check($sformatf("t5_nodone_%0d", i), 32'(done), 32'd0);
    end
    run_op("t5_after", 8'h80, 8'h7F, 1'b0);
    check("t5_after_diff", 32'(diff), 32'h01);
    check("t5_after_bout", 32'(bout), 32'd0);

    // Randomised operations against the model
    for (int i = 0; i < 20; i++) begin
      ra   = $urandom_range(0, 255);
      rb   = $urandom_range(0, 255);
      rbin = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rb, rbin);
    end

    // T6: start held high, operands change only at each done
    wait_idle("t6");
    tick();
    ra    = $urandom_range(0, 255);
    rb    = $urandom_range(0, 255);
    rbin  = 1'($urandom_range(0, 1));
    a     = ra;
    b     = rb;
    bin   = rbin;
    exp_q.push_back(model(ra, rb, rbin));
    start  = 1'b1;
    n      = 0;
    ndone  = 0;
    last_n = 0;
    while (ndone < 3 && n < 100) begin
      tick();
      n++;
      if (done) begin
        e = exp_q.pop_front();
        check($sformatf("t6_diff_%0d", ndone), 32'(diff), 32'(e[W-1:0]));
        check($sformatf("t6_bout_%0d", ndone), 32'(bout), 32'(e[W]));
        if (ndone == 0) check("t6_first_latency", 32'(n), 32'(W + 1));
        else check($sformatf("t6_spacing_%0d", ndone), 32'(n - last_n), 32'(W + 2));
        last_n = n;
        ndone++;
        if (ndone < 3) begin
          ra   = $urandom_range(0, 255);
          rb   = $urandom_range(0, 255);
          rbin = 1'($urandom_range(0, 1));
          a    = ra;
          b    = rb;
          bin  = rbin;
          exp_q.push_back(model(ra, rb, rbin));
        end else begin
          start = 1'b0;
        end
      end
    end
    if (ndone < 3) fail("t6_done_count");
    tick();
    tick();
    check("t6_end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
